msf_frame_decoder: RTL and testbench
====================================

Name: msf_frame_decoder

Overview:
- Consumes the per-second symbol stream from the MSF decoder: valid strobe, second-00 flag, and A/B bits.
- Tracks the second index within the minute and assembles the 60-second frame.
- Checks the four MSF odd-parity bits and the 52A–59A end-of-minute pattern.
- At the next minute marker, publishes BCD year/month/day/day-of-week/hour/minute for the display/output stage.

Parameters:
- none

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- bits_valid_i  input  1  one-cycle strobe: one second's symbol available
- bits_is_second_00_i  input  1  qualifies bits_valid_i: symbol is the minute marker (second 00)
- bits_data_i  input  2  [1]=A bit, [0]=B bit; ignored when bits_is_second_00_i=1
- time_valid_o  output  1  one-cycle pulse: new time latched on fields
- frame_error_o  output  1  one-cycle pulse: synced frame rejected
- synced_o  output  1  a minute marker has been seen since reset
- year_o  output  8  BCD 00–99
- month_o  output  5  BCD 01–12
- day_o  output  6  BCD 01–31
- dow_o  output  3  0=Sunday…6=Saturday
- hour_o  output  6  BCD 00–23
- minute_o  output  7  BCD 00–59

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset: all outputs 0; sec_cnt=0; synced=0; shift register, parity and pattern registers cleared.
- Inputs are examined only in cycles where bits_valid_i=1; all other cycles hold state.
- Second counter (6-bit sec_cnt):
  - On marker (valid & is_second_00): sec_cnt←0.
  - On other valid: sec_cnt←sec_cnt+1, saturating at 63.
  - The stored value is the index of the symbol just received.
- Capture uses the post-increment index s of a non-marker symbol:
  - s in 17..51: shift A into a 35-bit register, MSB-first (A17 ends at bit 34).
  - s in 54..57: store B into pb[s-54].
  - s in 52..59: compare A against 0,1,1,1,1,1,1,0; any mismatch clears pat_ok.
  - pat_ok is set to 1 at each marker.
- Field mapping after 35 shifts, MSB-first: year=A17–24, month=A25–29, day=A30–35, dow=A36–38, hour=A39–44, minute=A45–51.
- Parity (odd) checks; each must be 1:
  - XOR(A17–24)^pb0
  - XOR(A25–35)^pb1
  - XOR(A36–38)^pb2
  - XOR(A39–51)^pb3
  - Parity is computed combinationally from the shift register at the marker.
- Frame evaluation, on a marker with synced=1:
  - frame_good = (sec_cnt==59) & pat_ok & all four parity checks true.
  - If good: latch all fields, pulse time_valid_o.
  - Otherwise: pulse frame_error_o; field outputs hold previous values.
  - Pulses occur in the cycle after the marker strobe; width exactly 1 cycle.
- Marker with synced=0: set synced, no pulse. The first partial frame after reset is always discarded.
- Leap-second minutes (61 seconds) and short minutes yield sec_cnt≠59 → frame_error_o.
- No marker after 63 seconds: sec_cnt saturates; the next marker produces frame_error_o. synced stays 1.
- Field values are not range-checked; BCD content is passed as received.
- Reset mid-frame clears everything, including synced.
- Reset asserted in the same cycle as a strobe: reset wins.
- Fields latch together, never partially. time_valid_o and frame_error_o are never high simultaneously.
- Latency: marker strobe at cycle N → pulse and updated fields visible at cycle N+1.

Test Plan:
- Good frame: reset, marker, then 59 symbols encoding 2023-03-15, dow 3, 14:37, correct parity and pattern, then marker → time_valid_o pulse; year_o=0x23, month_o=0x03, day_o=0x15, dow_o=3, hour_o=0x14, minute_o=0x37; frame_error_o=0.
- First frame after reset: good frame symbols with no prior marker → no time_valid_o at closing marker; synced_o rises; the following good frame validates.
- Parity fault: as the good frame but 57B inverted → frame_error_o pulse; fields keep the previous frame's values; time_valid_o=0.
- Length/pattern faults:
  - 58-symbol minute → frame_error_o.
  - 61-symbol minute → frame_error_o.
  - Valid frame with 59A=1 → frame_error_o.
- Reset mid-frame: assert rst_i at second 30 of a synced frame → outputs 0, synced_o=0; the next marker gives no pulse.
- Back-to-back: two consecutive good frames, 14:37 then 14:38, with idle cycles between strobes → two time_valid_o pulses; minute_o=0x37 then 0x38.

Source files
------------

// File: rtl/msf_frame_decoder.sv
// MSF time-code frame decoder.
// Takes one decoded symbol per second (minute marker or A/B bit pair),
// tracks the second index, collects the 35 time/date A bits, the four
// parity B bits and the 52A..59A end-of-minute pattern. At the next minute
// marker it either publishes the BCD fields or flags the frame as rejected.
module msf_frame_decoder (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bits_valid_i,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
    output logic       time_valid_o,
    output logic       frame_error_o,
    output logic       synced_o,
    output logic [7:0] year_o,
    output logic [4:0] month_o,
    output logic [5:0] day_o,
    output logic [2:0] dow_o,
    output logic [5:0] hour_o,
    output logic [6:0] minute_o
);

    // Second indices of interest within the minute
    localparam logic [5:0] SEC_FIELD_FIRST = 6'd17;
    localparam logic [5:0] SEC_FIELD_LAST  = 6'd51;
    localparam logic [5:0] SEC_PAT_FIRST   = 6'd52;
    localparam logic [5:0] SEC_PAT_LAST    = 6'd59;
    localparam logic [5:0] SEC_PB_FIRST    = 6'd54;
    localparam logic [5:0] SEC_PB_LAST     = 6'd57;
    localparam logic [5:0] SEC_LAST        = 6'd59;
    localparam logic [5:0] SEC_MAX         = 6'd63;

    // State registers
    logic [5:0]  r_sec_cnt;
    logic        r_synced;
    logic [34:0] r_shift;
    logic [3:0]  r_pb;
    logic        r_pat_ok;
    logic        r_time_valid;
    logic        r_frame_error;
    logic [7:0]  r_year;
    logic [4:0]  r_month;
    logic [5:0]  r_day;
    logic [2:0]  r_dow;
    logic [5:0]  r_hour;
    logic [6:0]  r_minute;

    // Combinational helpers
    logic        w_a_bit;
    logic        w_b_bit;
    logic        w_marker;
    logic        w_symbol;
    logic [5:0]  w_sec_next;
    logic        w_in_field;
    logic        w_in_pat;
    logic        w_in_pb;
    logic [1:0]  w_pb_idx;
    logic        w_pat_exp;
    logic [3:0]  w_par_ok;
    logic        w_frame_good;

    assign w_a_bit  = bits_data_i[1];
    assign w_b_bit  = bits_data_i[0];
    assign w_marker = bits_valid_i &  bits_is_second_00_i;
    assign w_symbol = bits_valid_i & ~bits_is_second_00_i;

    // Index the incoming non-marker symbol will occupy; stuck at 63 on
    // over-long minutes so a missing marker can never wrap back to 59.
    always_comb begin
        w_sec_next = r_sec_cnt;
        if (r_sec_cnt != SEC_MAX)
            w_sec_next = r_sec_cnt + 6'd1;
    end

    // Window decodes on the post-increment index
    always_comb begin
        w_in_field = (w_sec_next >= SEC_FIELD_FIRST) && (w_sec_next <= SEC_FIELD_LAST);
        w_in_pat   = (w_sec_next >= SEC_PAT_FIRST)   && (w_sec_next <= SEC_PAT_LAST);
        w_in_pb    = (w_sec_next >= SEC_PB_FIRST)    && (w_sec_next <= SEC_PB_LAST);
        // 52A and 59A are 0, 53A..58A are 1
        w_pat_exp  = (w_sec_next != SEC_PAT_FIRST) && (w_sec_next != SEC_PAT_LAST);
    end

    // s-54 for s in 54..57: low two bits of s are 2,3,0,1, so adding 2 mod 4
    // gives 0..3 without a full subtractor.
    assign w_pb_idx = w_sec_next[1:0] + 2'd2;

    // Second counter: cleared at the marker, counts every other symbol
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_sec_cnt <= '0;
        else if (w_marker)
            r_sec_cnt <= '0;
        else if (w_symbol)
            r_sec_cnt <= w_sec_next;
    end

    // Sync flag: set by the first marker after reset, held until reset
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_synced <= 1'b0;
        else if (w_marker)
            r_synced <= 1'b1;
    end

    // A-bit shift register for 17A..51A, MSB first (17A lands in bit 34)
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_shift <= '0;
        else if (w_symbol && w_in_field)
            r_shift <= {r_shift[33:0], w_a_bit};
    end

    // Parity B bits 54B..57B
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_pb <= '0;
        else if (w_symbol && w_in_pb)
            r_pb[w_pb_idx] <= w_b_bit;
    end

    // End-of-minute pattern tracker: rearmed at each marker, cleared on any miss
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_pat_ok <= 1'b0;
        else if (w_marker)
            r_pat_ok <= 1'b1;
        else if (w_symbol && w_in_pat && (w_a_bit != w_pat_exp))
            r_pat_ok <= 1'b0;
    end

    // Odd parity over each field group, including its B parity bit
    always_comb begin
        w_par_ok[0] = (^r_shift[34:27]) ^ r_pb[0];  // year      17A..24A
        w_par_ok[1] = (^r_shift[26:16]) ^ r_pb[1];  // month/day 25A..35A
        w_par_ok[2] = (^r_shift[15:13]) ^ r_pb[2];  // dow       36A..38A
        w_par_ok[3] = (^r_shift[12:0])  ^ r_pb[3];  // hour/min  39A..51A
        w_frame_good = (r_sec_cnt == SEC_LAST) && r_pat_ok && (&w_par_ok);
    end

    // Frame verdict at a synced marker: publish all fields together or flag an error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_time_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_year        <= '0;
            r_month       <= '0;
            r_day         <= '0;
            r_dow         <= '0;
            r_hour        <= '0;
            r_minute      <= '0;
        end else begin
            r_time_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_marker && r_synced) begin
                if (w_frame_good) begin
                    r_time_valid <= 1'b1;
                    r_year       <= r_shift[34:27];
                    r_month      <= r_shift[26:22];
                    r_day        <= r_shift[21:16];
                    r_dow        <= r_shift[15:13];
                    r_hour       <= r_shift[12:7];
                    r_minute     <= r_shift[6:0];
                end else begin
                    r_frame_error <= 1'b1;
                end
            end
        end
    end

    assign time_valid_o  = r_time_valid;
    assign frame_error_o = r_frame_error;
    assign synced_o      = r_synced;
    assign year_o        = r_year;
    assign month_o       = r_month;
    assign day_o         = r_day;
    assign dow_o         = r_dow;
    assign hour_o        = r_hour;
    assign minute_o      = r_minute;

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Self-checking bench for msf_frame_decoder: directed minutes from the test
// plan followed by randomized minutes, checked against a positional model.
module tb_msf_frame_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       bits_valid_i;
    logic       bits_is_second_00_i;
    logic [1:0] bits_data_i;
    logic       time_valid_o;
    logic       frame_error_o;
    logic       synced_o;
    logic [7:0] year_o;
    logic [4:0] month_o;
    logic [5:0] day_o;
    logic [2:0] dow_o;
    logic [5:0] hour_o;
    logic [6:0] minute_o;

    msf_frame_decoder dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .bits_valid_i        (bits_valid_i),
        .bits_is_second_00_i (bits_is_second_00_i),
        .bits_data_i         (bits_data_i),
        .time_valid_o        (time_valid_o),
        .frame_error_o       (frame_error_o),
        .synced_o            (synced_o),
        .year_o              (year_o),
        .month_o             (month_o),
        .day_o               (day_o),
        .dow_o               (dow_o),
        .hour_o              (hour_o),
        .minute_o            (minute_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    // Frame template being transmitted (index = second)
    logic fa [0:63];
    logic fb [0:63];

    // Reference model: symbols received since the last marker, by second index
    logic m_a [0:63];
    logic m_b [0:63];
    int   m_cnt;
    bit   m_synced;
    logic [31:0] e_year, e_month, e_day, e_dow, e_hour, e_minute;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] bcd(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    // Value of the A bits in seconds p..p+w-1, earliest second = MSB
    function automatic logic [31:0] fld(input int p, input int w);
        logic [31:0] v = '0;
        for (int k = 0; k < w; k++) v = {v[30:0], m_a[p+k]};
        return v;
    endfunction

    function automatic logic xr_m(input int lo, input int hi);
        logic x = 1'b0;
        for (int i = lo; i <= hi; i++) x = x ^ m_a[i];
        return x;
    endfunction

    function automatic logic xr_f(input int lo, input int hi);
        logic x = 1'b0;
        for (int i = lo; i <= hi; i++) x = x ^ fa[i];
        return x;
    endfunction

    task automatic put(input int p, input int w, input logic [31:0] v);
        for (int k = 0; k < w; k++) fa[p+k] = v[w-1-k];
    endtask

    // fault: 0 none, 1 invert 57B, 2 59A=1, 3 flip a pattern bit, 4 flip a parity bit
    task automatic build(input int y, input int mo, input int d, input int dw,
                         input int h, input int mi, input int fault);
        for (int i = 0; i < 64; i++) begin
            fa[i] = 1'($urandom);
            fb[i] = 1'($urandom);
        end
        put(17, 8, bcd(y));
        put(25, 5, bcd(mo));
        put(30, 6, bcd(d));
        put(36, 3, 32'(dw));
        put(39, 6, bcd(h));
        put(45, 7, bcd(mi));
        for (int i = 52; i <= 59; i++) fa[i] = (i != 52 && i != 59);
        fb[54] = ~xr_f(17, 24);
        fb[55] = ~xr_f(25, 35);
        fb[56] = ~xr_f(36, 38);
        fb[57] = ~xr_f(39, 51);
        case (fault)
            1: fb[57] = ~fb[57];
            2: fa[59] = 1'b1;
            3: begin int j = $urandom_range(52, 59); fa[j] = ~fa[j]; end
            4: begin int j = $urandom_range(54, 57); fb[j] = ~fb[j]; end
            default: ;
        endcase
    endtask

    // Send one symbol after a random idle gap; at a marker, check the verdict
    task automatic sym(input bit mk, input logic a, input logic b);
        logic etv = 1'b0, efe = 1'b0, good;
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        bits_valid_i        = 1'b1;
        bits_is_second_00_i = mk;
        bits_data_i         = mk ? 2'($urandom_range(0, 3)) : {a, b};
        if (mk) begin
            if (m_synced) begin
                good = (m_cnt == 59);
                for (int i = 52; i <= 59; i++)
                    if (m_a[i] !== ((i == 52 || i == 59) ? 1'b0 : 1'b1)) good = 1'b0;
                if ((xr_m(17, 24) ^ m_b[54]) !== 1'b1) good = 1'b0;
                if ((xr_m(25, 35) ^ m_b[55]) !== 1'b1) good = 1'b0;
                if ((xr_m(36, 38) ^ m_b[56]) !== 1'b1) good = 1'b0;
                if ((xr_m(39, 51) ^ m_b[57]) !== 1'b1) good = 1'b0;
                if (good) begin
                    etv = 1'b1;
                    e_year = fld(17, 8); e_month = fld(25, 5); e_day = fld(30, 6);
                    e_dow  = fld(36, 3); e_hour  = fld(39, 6); e_minute = fld(45, 7);
                end else begin
                    efe = 1'b1;
                end
            end
            m_synced = 1'b1;
            m_cnt = 0;
        end else begin
            if (m_cnt < 63) m_cnt++;
            m_a[m_cnt] = a;
            m_b[m_cnt] = b;
        end
        @(negedge clk_i);
        bits_valid_i        = 1'b0;
        bits_is_second_00_i = 1'b0;
        if (mk) begin
            chk("time_valid", 32'(time_valid_o), 32'(etv));
            chk("frame_error", 32'(frame_error_o), 32'(efe));
            chk("synced", 32'(synced_o), 32'(1));
            chk("year", 32'(year_o), e_year);
            chk("month", 32'(month_o), e_month);
            chk("day", 32'(day_o), e_day);
            chk("dow", 32'(dow_o), e_dow);
            chk("hour", 32'(hour_o), e_hour);
            chk("minute", 32'(minute_o), e_minute);
            @(negedge clk_i);
            chk("pulse_width", 32'({time_valid_o, frame_error_o}), 32'(0));
        end
    endtask

    // Symbols 1..len of the current template, then optionally the closing marker
    task automatic send_min(input int len, input bit close);
        for (int i = 1; i <= len; i++)
            sym(1'b0, (i <= 63) ? fa[i] : 1'($urandom), (i <= 63) ? fb[i] : 1'($urandom));
        if (close) sym(1'b1, 1'b0, 1'b0);
    endtask

    task automatic minute(input int len, input int y, input int mo, input int d,
                          input int dw, input int h, input int mi, input int fault);
        build(y, mo, d, dw, h, mi, fault);
        send_min(len, 1'b1);
    endtask

    // Reset held for two cycles with a marker strobe colliding in the first
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        bits_valid_i = 1'b1;
        bits_is_second_00_i = 1'b1;
        bits_data_i = 2'b00;
        @(negedge clk_i);
        bits_valid_i = 1'b0;
        bits_is_second_00_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_synced", 32'(synced_o), 32'(0));
        chk("rst_pulses", 32'({time_valid_o, frame_error_o}), 32'(0));
        chk("rst_fields", 32'({year_o, month_o, day_o, dow_o, hour_o, minute_o}), 32'(0));
        m_synced = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 64; i++) begin m_a[i] = 1'b0; m_b[i] = 1'b0; end
        e_year = 0; e_month = 0; e_day = 0; e_dow = 0; e_hour = 0; e_minute = 0;
    endtask

    initial begin
        rst_i = 1'b0;
        bits_valid_i = 1'b0;
        bits_is_second_00_i = 1'b0;
        bits_data_i = 2'b00;
        do_reset();

        // First frame after reset is only used to sync
        minute(59, 23, 3, 15, 3, 14, 36, 0);
        // Good frame 2023-03-15 dow 3 14:37
        minute(59, 23, 3, 15, 3, 14, 37, 0);
        chk("spec_year", 32'(year_o), 32'h23);
        chk("spec_month", 32'(month_o), 32'h03);
        chk("spec_day", 32'(day_o), 32'h15);
        chk("spec_dow", 32'(dow_o), 32'd3);
        chk("spec_hour", 32'(hour_o), 32'h14);
        chk("spec_minute", 32'(minute_o), 32'h37);

        // Parity fault: 57B inverted, fields must keep 14:37
        minute(59, 23, 3, 15, 3, 14, 38, 1);
        chk("hold_minute", 32'(minute_o), 32'h37);

        // Short, long, bad 59A, missing marker (saturation)
        minute(58, 23, 3, 15, 3, 14, 39, 0);
        minute(61, 23, 3, 15, 3, 14, 40, 0);
        minute(59, 23, 3, 15, 3, 14, 41, 2);
        minute(70, 23, 3, 15, 3, 14, 42, 0);

        // Back-to-back good frames
        minute(59, 23, 3, 15, 3, 14, 37, 0);
        chk("b2b_first", 32'(minute_o), 32'h37);
        minute(59, 23, 3, 15, 3, 14, 38, 0);
        chk("b2b_second", 32'(minute_o), 32'h38);

        // Reset at second 30 of a synced frame; next marker only resyncs
        build(24, 12, 31, 6, 23, 59, 0);
        send_min(30, 1'b0);
        do_reset();
        sym(1'b1, 1'b0, 1'b0);
        minute(59, 24, 12, 31, 6, 23, 59, 0);

        // Randomized minutes: mostly good, some faulted or mis-sized
        for (int n = 0; n < 16; n++) begin
            int len, fault;
            len   = ($urandom_range(0, 3) == 0) ? $urandom_range(56, 62) : 59;
            fault = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            minute(len, $urandom_range(0, 99), $urandom_range(1, 12), $urandom_range(1, 31),
                   $urandom_range(0, 6), $urandom_range(0, 23), $urandom_range(0, 59), fault);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
